// File: rtl/mac_job_scheduler_pkg.sv
// mac_sched_pkg
// Shared types and defaults for the MAC job scheduler slice.
//   state_e     : scheduler FSM states
//   DEF_*       : default parameter values for the scheduler and its interface
//   wrap_inc    : increment with wrap-around at a modulus (round-robin pointer)
package mac_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_RELEASE = 3'd3,
        S_DRAIN   = 3'd4
    } state_e;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 1024;
    localparam int DEF_CNT_W   = 16;

    // Next index after v in a ring of n entries.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/mac_job_scheduler_if.sv
// mac_job_scheduler_if
// Bundles the requester handshake, the MAC start/done pins and the status
// outputs of the scheduler.
//   master : scheduler side (drives gnt/ack/err/mac_start/status, reads req/mac_done)
//   slave  : client/MAC side (drives req/mac_done, reads everything else)
interface mac_job_scheduler_if import mac_sched_pkg::*; #(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W
) ();

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] ack;
    logic             err;
    logic             mac_start;
    logic             mac_done;
    logic             busy;
    logic [IDX_W-1:0] owner;
    logic [CNT_W-1:0] jobs_done;
    logic [CNT_W-1:0] jobs_err;

    modport master (
        input  req, mac_done,
        output gnt, ack, err, mac_start, busy, owner, jobs_done, jobs_err
    );

    modport slave (
        output req, mac_done,
        input  gnt, ack, err, mac_start, busy, owner, jobs_done, jobs_err
    );

endinterface

// File: rtl/mac_job_scheduler_rr_pick.sv
// rr_pick
// Combinational round-robin priority picker: returns the first set bit of
// req_i found by searching upward from ptr_i, wrapping past N_REQ-1 to 0.
//   req_i   : request vector
//   ptr_i   : search start index (highest priority)
//   valid_o : at least one request is set
//   idx_o   : index of the winning request
module rr_pick import mac_sched_pkg::*; #(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the farthest offset back to ptr_i so the last hit written is
    // the nearest one after ptr_i; this avoids a loop break.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        valid_o  = 1'b0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr_i) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                valid_o = 1'b1;
                idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mac_job_scheduler.sv
// mac_job_scheduler
// Shares one matrix MAC engine among N_REQ requesters. A round-robin winner
// is granted, the MAC is started with a one-cycle pulse, and the owner gets a
// one-cycle ack when done arrives or when the watchdog forces release.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : master modport carrying req/gnt/ack/err, mac_start/mac_done,
//            busy, owner and the saturating job/error counters
module mac_job_scheduler import mac_sched_pkg::*; #(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input logic                 clk,
    input logic                 reset,
    mac_job_scheduler_if.master bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] jobs_done_q, jobs_done_d;
    logic [CNT_W-1:0] jobs_err_q, jobs_err_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] owner_onehot;

    logic [N_REQ-1:0] gnt_s;
    logic [N_REQ-1:0] ack_s;
    logic             err_s;
    logic             start_s;
    logic             busy_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign owner_onehot = N_REQ'(1) << owner_q;

    // State register plus all datapath registers; reset drops any job in
    // flight without issuing ack or err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            wdog_q      <= '0;
            tmo_q       <= 1'b0;
            jobs_done_q <= '0;
            jobs_err_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            wdog_q      <= wdog_d;
            tmo_q       <= tmo_d;
            jobs_done_q <= jobs_done_d;
            jobs_err_q  <= jobs_err_d;
        end
    end

    // Next-state logic and output decode. Outputs depend only on registered
    // state so the MAC and clients never see a combinational path from req.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        wdog_d      = wdog_q;
        tmo_d       = tmo_q;
        jobs_done_d = jobs_done_q;
        jobs_err_d  = jobs_err_q;
        gnt_s       = '0;
        ack_s       = '0;
        err_s       = 1'b0;
        start_s     = 1'b0;
        busy_s      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = S_START;
                end
            end
            S_START: begin
                start_s = 1'b1;
                gnt_s   = owner_onehot;
                wdog_d  = '0;
                tmo_d   = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                gnt_s = owner_onehot;
                // done is tested first so it wins a tie with the watchdog.
                if (bus.mac_done) begin
                    state_d = S_RELEASE;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = S_RELEASE;
                    tmo_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_RELEASE: begin
                ack_s = owner_onehot;
                err_s = tmo_q;
                if (tmo_q) begin
                    if (jobs_err_q != {CNT_W{1'b1}}) begin
                        jobs_err_d = jobs_err_q + 1'b1;
                    end
                end else begin
                    if (jobs_done_q != {CNT_W{1'b1}}) begin
                        jobs_done_d = jobs_done_q + 1'b1;
                    end
                end
                ptr_d = IDX_W'(wrap_inc(int'(owner_q), N_REQ));
                // A done still held high must not complete the next job.
                state_d = bus.mac_done ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!bus.mac_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.gnt       = gnt_s;
    assign bus.ack       = ack_s;
    assign bus.err       = err_s;
    assign bus.mac_start = start_s;
    assign bus.busy      = busy_s;
    assign bus.owner     = owner_q;
    assign bus.jobs_done = jobs_done_q;
    assign bus.jobs_err  = jobs_err_q;

endmodule
